fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the rv32i pipeline, directly upstream of the decode stage. It owns the fetch PC, issues single-outstanding requests to instruction memory, and buffers returned words in a small FIFO. Each cycle it presents one `{pc, inst}` pair to decode. On a taken jump or branch signalled back by decode, it redirects the fetch PC and squashes buffered and in-flight instructions.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.
- `DEPTH`, default 2: FIFO entries, power of two, at least 2.
- `NOP`, default 32'h0000_0013: bubble word (`addi x0,x0,0`) driven when no valid instruction exists.

Ports:
- `clk` in 1: single clock; all state on posedge.
- `rst_n` in 1: reset, synchronous, active-low.
- `imem_req` out 1: request held to instruction memory.
- `imem_addr` out 32: word-aligned fetch address; stable while `imem_req` is high.
- `imem_ack` in 1: `imem_rdata` is valid this cycle; completes the held request.
- `imem_rdata` in 32: fetched instruction word.
- `jump` in 1: taken redirect from decode (`o_jump`).
- `jump_addr` in 32: redirect target; bits [1:0] are ignored and treated as 0.
- `stall` in 1: downstream cannot accept an instruction this cycle.
- `pc` out 32: PC of the presented instruction.
- `inst` out 32: presented instruction, or `NOP`.
- `inst_valid` out 1: `inst` and `pc` are a real fetched instruction.

## Operation
- **State**
  - `fpc`: next fetch address.
  - FIFO of `{pc, inst}` with `DEPTH` entries and a `count` of occupied entries.
  - FSM with states IDLE, FETCH, DISCARD.
- **IDLE**
  - Entered on reset. `imem_req` is 0.
  - Moves to FETCH on the first cycle with `rst_n` high.
- **FETCH**
  - A new request starts when no request is held and registered `count < DEPTH`. It drives `imem_req=1` and `imem_addr=fpc`.
  - The request is held unchanged until `imem_ack`.
  - On `imem_ack` without `jump`:
    - push `{fpc, imem_rdata}`;
    - `fpc += 4`, wrapping modulo 2^32;
    - the request is complete, and a new one may start the next cycle.
- **Output**
  - `inst_valid = (count != 0) && !jump`.
  - `inst`/`pc` = FIFO head when `inst_valid`, else `NOP`/`fpc`.
  - Pop when `inst_valid && !stall`.
- **Redirect** (`jump=1`)
  - `fpc <= {jump_addr[31:2], 2'b00}`.
  - FIFO is flushed (`count <= 0`), overriding any push or pop that cycle.
  - If a request is held and `imem_ack=0`, go to DISCARD.
  - If `imem_ack=1` that cycle, the data is dropped and the FSM stays in FETCH.
- **DISCARD**
  - Keeps `imem_req` and the old `imem_addr` until `imem_ack`.
  - Drops the returned data, then returns to FETCH. The new request goes to the redirected `fpc` next cycle.
  - A further `jump` in DISCARD updates `fpc` again and stays in DISCARD.
- `imem_ack` while no request is held is ignored.
- Push and pop in the same cycle leave `count` unchanged. A push never occurs when `count == DEPTH`; request gating guarantees this.

## Timing
- **Reset values** (cycle after `rst_n` sampled low):
  - `imem_req=0`, `imem_addr=RESET_PC`;
  - `count=0`, `inst_valid=0`, `inst=NOP`, `pc=RESET_PC`;
  - `fpc=RESET_PC`, state IDLE.
- **Reset mid-request:** request is abandoned and state is reset. Memory shares `rst_n`.
- **After reset:** first cycle with `rst_n` high is IDLE. `imem_req` rises the following cycle at `RESET_PC`.
- **Latency:** ack in cycle N gives `inst_valid=1` with that word in cycle N+1.
- **Zero-wait memory:** ack in the same cycle as the request start sustains one instruction per cycle with `DEPTH>=2` and no stall.
- **Redirect latency:** `jump` in cycle N gives `imem_req` at the target in cycle N+1 if no request is held (FETCH). The earliest valid target instruction is in cycle N+2.
- `jump` gates `inst_valid` combinationally in the same cycle. Decode therefore latches `NOP` and its `o_jump` deasserts one cycle later.
- **Stall:** the head is held stable. Fetching continues until `count == DEPTH`, then `imem_req` stays 0 once no request is held.

## Test plan
- **Straight-line fetch:** reset with `RESET_PC=0`, zero-wait memory returning `addr|0x100`, no stall. Expect `inst_valid` from the 3rd cycle after `rst_n` rises, `pc` 0,4,8,12… on consecutive cycles, `inst`=`pc|0x100`.
- **Wait-state memory:** ack 3 cycles after each request. Expect `imem_addr` stable while `imem_req` is held, one instruction per 4 cycles, `inst=NOP` between.
- **Stall until full:** assert `stall` for 6 cycles with `DEPTH=2`. Expect `pc=0` held, `count` saturating at 2, `imem_req` low once no request is held. Release `stall`: `pc` 0,4 then fetch resumes at 8.
- **Redirect with idle memory:** `jump=1`, `jump_addr=0x42` in cycle N. Expect `inst=NOP` in cycle N, `imem_addr=0x40` in N+1, `pc=0x40` valid in N+2.
- **Redirect during wait:** jump to 0x200 while the request to 0x10 is waiting. Expect the 0x10 data dropped on its ack, the next request at 0x200, and no 0x10 instruction presented.
- **Corner cases:**
  - Jump coinciding with ack: data dropped, next request at target.
  - `rst_n` low mid-request: `imem_req=0` the next cycle and `pc=RESET_PC`.
  - `fpc=0xFFFFFFFC` wraps to 0.

Source files
------------

// File: rtl/fetch_unit.sv
// rv32i instruction fetch: single-outstanding imem requests, small {pc, inst} FIFO toward decode,
// and redirect/squash on taken jumps signalled back by decode.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2,
   parameter logic [31:0] NOP      = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        jump,
   input  logic [31:0] jump_addr,
   input  logic        stall,
   output logic [31:0] pc,
   output logic [31:0] inst,
   output logic        inst_valid
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef enum logic [1:0] {IDLE, FETCH, DISCARD} state_t;
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } entry_t;

   state_t        state, state_nx;
   logic          held;
   logic [31:0]   req_addr, fpc;
   entry_t        fifo [DEPTH];
   entry_t        head;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic          start, done, push, pop;
   logic          unused_jaddr_lsb;

   assign unused_jaddr_lsb = ^jump_addr[1:0];

   // A new request is never started in a jump cycle, so the target goes out on the next cycle.
   always_comb begin
      state_nx = state;
      start    = 1'b0;
      case (state)
         IDLE:    state_nx = FETCH;
         FETCH: begin
            start = !held && (count < FULL) && !jump;
            if (jump && held && !imem_ack) state_nx = DISCARD;
         end
         DISCARD: if (imem_ack) state_nx = FETCH;
         default: state_nx = IDLE;
      endcase
   end

   assign imem_req   = held || start;
   assign imem_addr  = held ? req_addr : fpc;
   assign done       = imem_req && imem_ack;
   assign push       = done && (state == FETCH) && !jump;
   assign inst_valid = (count != '0) && !jump;
   assign pop        = inst_valid && !stall;
   assign head       = fifo[rd_ptr];
   assign pc         = inst_valid ? head.pc   : fpc;
   assign inst       = inst_valid ? head.inst : NOP;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         held     <= 1'b0;
         req_addr <= RESET_PC;
         fpc      <= RESET_PC;
         count    <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
      end else begin
         state <= state_nx;
         if (done) begin
            held <= 1'b0;
         end else if (start) begin
            held     <= 1'b1;
            req_addr <= fpc;
         end
         if (jump)      fpc <= {jump_addr[31:2], 2'b00};
         else if (push) fpc <= fpc + 32'd4;
         // Flush wins over any push/pop in the same cycle.
         if (jump) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
               2'b10:   count <= count + CW'(1);
               2'b01:   count <= count - CW'(1);
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo[wr_ptr] <= '{pc: fpc, inst: imem_rdata};
   end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: latency-programmable memory responder, scoreboard of expected pcs
// consumed on every decode pop, plus cycle-exact checks of request/redirect timing.
module tb_fetch_unit;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req, imem_ack;
   logic [31:0] imem_addr, imem_rdata;
   logic        jump, stall;
   logic [31:0] jump_addr;
   logic [31:0] pc, inst;
   logic        inst_valid;

   int          n_cmp = 0;
   int          n_err = 0;
   int          lat;
   int          wcnt;
   logic        mon_en;
   logic [31:0] q [$];

   fetch_unit #(.RESET_PC(32'h0), .DEPTH(2), .NOP(NOP)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .jump(jump), .jump_addr(jump_addr), .stall(stall),
      .pc(pc), .inst(inst), .inst_valid(inst_valid)
   );

   always #5 clk = ~clk;

   // Memory: acks a held request after lat wait cycles (lat=0 acks in the request cycle).
   assign imem_ack   = imem_req && (wcnt >= lat);
   assign imem_rdata = imem_addr | 32'h100;
   always @(posedge clk) begin
      if (!rst_n || !imem_req || imem_ack) wcnt <= 0;
      else                                 wcnt <= wcnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Every instruction taken by decode must be the next expected pc.
   always @(negedge clk) begin
      if (mon_en) begin
         if (inst_valid && !stall) begin
            chk("sb_avail", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
               logic [31:0] e;
               e = q.pop_front();
               chk("sb_pc", pc, e);
               chk("sb_inst", inst, e | 32'h100);
            end
         end else if (!inst_valid) begin
            chk("bubble_nop", inst, NOP);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int max);
      int n;
      n = 0;
      #1;
      while (q.size() != 0 && n < max) begin
         tick();
         @(negedge clk);
         #1;
         n++;
      end
      chk("drain", 32'(q.size()), 32'd0);
   endtask

   task automatic redirect(input logic [31:0] a);
      jump      = 1'b1;
      jump_addr = a;
      @(negedge clk);
      chk("jmp_valid", 32'(inst_valid), 32'd0);
      chk("jmp_nop", inst, NOP);
      tick();
      jump = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; jump = 1'b0; jump_addr = '0; stall = 1'b0; lat = 0; mon_en = 1'b0;
      repeat (3) tick();
      mon_en = 1'b1;
      @(negedge clk);
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_valid", 32'(inst_valid), 32'd0);
      chk("rst_inst", inst, NOP);
      chk("rst_pc", pc, 32'h0);

      // Straight-line, zero-wait memory
      for (int i = 0; i < 8; i++) q.push_back(32'(i * 4));
      tick(); rst_n = 1'b1;
      @(negedge clk);
      chk("idle_req", 32'(imem_req), 32'd0);
      tick();
      @(negedge clk);
      chk("first_req", 32'(imem_req), 32'd1);
      chk("first_addr", imem_addr, 32'h0);
      chk("first_valid", 32'(inst_valid), 32'd0);
      for (int i = 0; i < 8; i++) begin
         tick();
         @(negedge clk);
         chk("sl_valid", 32'(inst_valid), 32'd1);
      end
      drain(20);

      // Redirect with idle memory
      tick();
      redirect(32'h42);
      q.push_back(32'h40); q.push_back(32'h44); q.push_back(32'h48);
      @(negedge clk);
      chk("rd_req", 32'(imem_req), 32'd1);
      chk("rd_addr", imem_addr, 32'h40);
      tick();
      @(negedge clk);
      chk("rd_valid", 32'(inst_valid), 32'd1);
      chk("rd_pc", pc, 32'h40);
      drain(20);

      // Stall until full
      tick(); stall = 1'b1;
      redirect(32'h0);
      @(negedge clk);
      chk("st_req0", imem_addr, 32'h0);
      tick();
      @(negedge clk);
      chk("st_valid", 32'(inst_valid), 32'd1);
      chk("st_pc0", pc, 32'h0);
      for (int i = 0; i < 4; i++) begin
         tick();
         @(negedge clk);
         chk("st_noreq", 32'(imem_req), 32'd0);
         chk("st_hold_pc", pc, 32'h0);
      end
      q.push_back(32'h0); q.push_back(32'h4); q.push_back(32'h8); q.push_back(32'hC);
      tick(); stall = 1'b0;
      @(negedge clk);
      chk("st_rel_noreq", 32'(imem_req), 32'd0);
      drain(20);

      // Wait-state memory: one instruction every 4 cycles
      tick(); lat = 3;
      redirect(32'h8);
      q.push_back(32'h8); q.push_back(32'hC);
      for (int i = 1; i <= 9; i++) begin
         logic [31:0] ea;
         ea = (i <= 4) ? 32'h8 : (i <= 8) ? 32'hC : 32'h10;
         @(negedge clk);
         chk("ws_req", 32'(imem_req), 32'd1);
         chk("ws_addr", imem_addr, ea);
         chk("ws_valid", 32'(inst_valid), 32'((i == 5) || (i == 9)));
         if (i < 9) tick();
      end

      // Redirect while the 0x10 request is waiting
      tick();
      redirect(32'h200);
      @(negedge clk);
      chk("dis_req", 32'(imem_req), 32'd1);
      chk("dis_addr", imem_addr, 32'h10);
      tick();
      @(negedge clk);
      chk("dis_addr_ack", imem_addr, 32'h10);
      tick(); lat = 0;
      q.push_back(32'h200); q.push_back(32'h204);
      @(negedge clk);
      chk("dis_new_req", 32'(imem_req), 32'd1);
      chk("dis_new_addr", imem_addr, 32'h200);
      drain(20);

      // Jump in the same cycle as an ack
      tick(); lat = 1;
      redirect(32'h400);
      q.push_back(32'h400);
      @(negedge clk);
      chk("ja_addr", imem_addr, 32'h400);
      tick();
      tick();
      @(negedge clk);
      chk("ja_addr2", imem_addr, 32'h404);
      tick();
      jump = 1'b1; jump_addr = 32'h300;
      @(negedge clk);
      chk("ja_ack", 32'(imem_ack), 32'd1);
      chk("ja_valid", 32'(inst_valid), 32'd0);
      tick(); jump = 1'b0;
      q.push_back(32'h300);
      @(negedge clk);
      chk("ja_req", 32'(imem_req), 32'd1);
      chk("ja_tgt", imem_addr, 32'h300);
      drain(20);

      // PC wrap past 0xFFFFFFFC
      tick(); lat = 0;
      redirect(32'hFFFF_FFFC);
      q.push_back(32'hFFFF_FFFC); q.push_back(32'h0); q.push_back(32'h4);
      @(negedge clk);
      chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
      drain(20);

      // Reset in the middle of a held request
      tick(); lat = 3;
      redirect(32'h500);
      @(negedge clk);
      chk("mr_req", 32'(imem_req), 32'd1);
      tick(); rst_n = 1'b0;
      tick();
      @(negedge clk);
      chk("mr_noreq", 32'(imem_req), 32'd0);
      chk("mr_pc", pc, 32'h0);
      chk("mr_valid", 32'(inst_valid), 32'd0);
      chk("mr_inst", inst, NOP);
      chk("sb_final", 32'(q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
